// File: rtl/key_debounce_arbiter.sv
// Debounces N_KEYS buttons with one shared stability counter.
// Keys whose synchronized level differs from their debounced level get the counter in round-robin order.
module key_debounce_arbiter #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1500000,
    parameter int unsigned CNT_W           = 21,
    parameter int unsigned IDX_W           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_level,
    output logic              busy,
    output logic [IDX_W-1:0]  active_idx
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_KEYS-1:0]  sync1_q, sync2_q;
    logic [N_KEYS-1:0]  level_q, level_d;
    logic [N_KEYS-1:0]  pulse_q, pulse_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               val_q, val_d;
    logic               busy_q, busy_d;

    logic [N_KEYS-1:0]  diff;
    logic [N_KEYS-1:0]  active_onehot;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic               grant_val;
    logic               stable;
    int unsigned        cand;

    // Two-flop synchronizer for the asynchronous raw inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    assign diff          = sync2_q ^ level_q;
    assign active_onehot = N_KEYS'(1) << idx_q;
    assign stable        = (|(sync2_q & active_onehot)) == val_q;
    assign next_ptr      = IDX_W'((32'(idx_q) + 32'd1) % N_KEYS);
    assign grant_val     = |(sync2_q & (N_KEYS'(1) << grant_idx));

    // Round-robin search for the first pending key starting at rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cand = (32'(rr_ptr_q) + i) % N_KEYS;
            if (!grant_found && (|(diff & (N_KEYS'(1) << cand)))) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            level_q  <= '0;
            pulse_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            val_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        pulse_d  = '0;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    idx_d   = grant_idx;
                    val_d   = grant_val;
                    cnt_d   = CNT_W'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!stable) begin
                    rr_ptr_d = next_ptr;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    // Commit; a pulse is only emitted on a press
                    level_d  = val_q ? (level_q | active_onehot) : (level_q & ~active_onehot);
                    pulse_d  = val_q ? active_onehot : '0;
                    rr_ptr_d = next_ptr;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SETTLE);
    end

    assign key_pulse  = pulse_q;
    assign key_level  = level_q;
    assign busy       = busy_q;
    assign active_idx = idx_q;

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Bench for key_debounce_arbiter: edge-indexed reference model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_key_debounce_arbiter;

    localparam int N  = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_pulse;
    logic [3:0] key_level;
    logic       busy;
    logic [1:0] active_idx;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce_arbiter #(
        .N_KEYS(4), .DEBOUNCE_CYCLES(DC), .CNT_W(4), .IDX_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_pulse(key_pulse),
        .key_level(key_level), .busy(busy), .active_idx(active_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synchronized value is the raw sample from two edges ago;
    // a grant made at edge g commits at edge g+DC if the key never moved.
    logic [3:0] m_level = '0, m_pulse = '0;
    logic       m_busy = 1'b0, m_val = 1'b0;
    int         m_idx = 0, m_rr = 0, m_g = 0, edge_n = 0;
    logic [3:0] hist[$];

    initial begin
        logic [3:0] ks, df;
        bit         fnd;
        int         c;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_level = '0; m_pulse = '0; m_busy = 1'b0; m_idx = 0; m_rr = 0;
                hist.delete();
            end else begin
                ks = (hist.size() >= 2) ? hist[hist.size()-2] : 4'h0;
                df = ks ^ m_level;
                m_pulse = '0;
                if (!m_busy) begin
                    fnd = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        c = (m_rr + i) % N;
                        if (!fnd && df[c]) begin
                            fnd = 1'b1; m_idx = c; m_val = ks[c]; m_g = edge_n; m_busy = 1'b1;
                        end
                    end
                end else if (ks[m_idx] != m_val) begin
                    m_busy = 1'b0;
                    m_rr   = (m_idx + 1) % N;
                end else if (edge_n - m_g == DC) begin
                    m_level[m_idx] = m_val;
                    if (m_val) m_pulse[m_idx] = 1'b1;
                    m_busy = 1'b0;
                    m_rr   = (m_idx + 1) % N;
                end
                hist.push_back(key);
                if (hist.size() > 3) void'(hist.pop_front());
                edge_n++;
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("pulse", 32'(key_pulse), 32'(m_pulse));
            chk("level", 32'(key_level), 32'(m_level));
            chk("busy",  32'(busy),      32'(m_busy));
            if (m_busy) chk("active_idx", 32'(active_idx), 32'(m_idx));
        end
    end

    // Offset k counts edges after the stimulus change, first edge is k=0
    task automatic wait_pulse(input int max, output int e, output logic [3:0] p);
        e = -1; p = '0;
        for (int k = 0; k < max; k++) begin
            @(posedge clk); #1;
            if (key_pulse != 0) begin e = k; p = key_pulse; break; end
        end
    endtask

    task automatic wait_level(input logic [3:0] exp, input int max, output int e, output int np);
        e = -1; np = 0;
        for (int k = 0; k < max; k++) begin
            @(posedge clk); #1;
            if (key_pulse != 0) np++;
            if (key_level == exp) begin e = k; break; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         e, e1, e2, np, rises;
        logic [3:0] p, p1, p2, prev, l1, l2;
        logic       pb;

        // 1: reset with all keys high, then release with keys low
        rst_n = 1'b0; key = 4'hF;
        repeat (3) @(posedge clk); #1;
        chk("rst_pulse", 32'(key_pulse), 0);
        chk("rst_level", 32'(key_level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idx", 32'(active_idx), 0);
        key = 4'h0; rst_n = 1'b1;
        repeat (12) @(posedge clk); #1;
        chk("post_rst_level", 32'(key_level), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // 2: clean press and release of key 1
        key = 4'b0010;
        wait_pulse(20, e, p);
        chk("t2_press_lat", 32'(e), 10);
        chk("t2_press_pulse", 32'(p), 32'h2);
        chk("t2_press_level", 32'(key_level), 32'h2);
        key = 4'b0000;
        @(posedge clk); #1;
        chk("t2_pulse_clear", 32'(key_pulse), 0);
        wait_level(4'b0000, 20, e, np);
        chk("t2_release_lat", 32'(e), 9);
        chk("t2_release_pulses", 32'(np), 0);

        // 3: key 0 bounces every 3 cycles, then settles high
        np = 0; rises = 0; pb = busy;
        for (int t = 0; t < 24; t++) begin
            if (t % 3 == 0) key[0] = ((t / 3) % 2 == 0);
            @(posedge clk); #1;
            if (key_pulse != 0) np++;
            if (busy && !pb) rises++;
            pb = busy;
        end
        chk("t3_bounce_pulses", 32'(np), 0);
        chk("t3_busy_rises", 32'(rises), 4);
        key[0] = 1'b1;
        wait_pulse(20, e, p);
        chk("t3_final_lat", 32'(e), 10);
        chk("t3_final_pulse", 32'(p), 32'h1);
        key = 4'b0000;
        wait_level(4'b0000, 20, e, np);
        chk("t3_release_lat", 32'(e), 10);
        repeat (2) @(posedge clk); #1;

        // 5: key 3 glitch of 5 cycles is rejected
        key = 4'b1000; np = 0;
        for (int t = 0; t < 12; t++) begin
            if (t == 5) key = 4'b0000;
            @(posedge clk); #1;
            if (key_pulse != 0) np++;
            if (t == 4) chk("t5_busy_mid", 32'(busy), 1);
            if (t == 4) chk("t5_idx_mid", 32'(active_idx), 3);
            if (t == 8) chk("t5_busy_end", 32'(busy), 0);
        end
        chk("t5_pulses", 32'(np), 0);
        chk("t5_level", 32'(key_level), 0);

        // 4: keys 0 and 2 together with rr_ptr back at 0
        key = 4'b0101; np = 0; e1 = -1; e2 = -1; p1 = '0; p2 = '0;
        for (int t = 0; t < 25; t++) begin
            @(posedge clk); #1;
            if (key_pulse != 0) begin
                if (np == 0) begin e1 = t; p1 = key_pulse; end
                else begin e2 = t; p2 = key_pulse; end
                np++;
            end
        end
        chk("t4_npulses", 32'(np), 2);
        chk("t4_first_lat", 32'(e1), 10);
        chk("t4_first_pulse", 32'(p1), 32'h1);
        chk("t4_second_lat", 32'(e2), 19);
        chk("t4_second_pulse", 32'(p2), 32'h4);
        key = 4'b0000; np = 0; e1 = -1; e2 = -1; l1 = '0; l2 = '0; prev = key_level;
        for (int t = 0; t < 25; t++) begin
            @(posedge clk); #1;
            if (key_pulse != 0) np++;
            if (key_level != prev) begin
                if (e1 < 0) begin e1 = t; l1 = key_level; end
                else begin e2 = t; l2 = key_level; end
            end
            prev = key_level;
        end
        chk("t4_rel_pulses", 32'(np), 0);
        chk("t4_rel_first_lat", 32'(e1), 10);
        chk("t4_rel_first_level", 32'(l1), 32'h4);
        chk("t4_rel_second_lat", 32'(e2), 19);
        chk("t4_rel_second_level", 32'(l2), 32'h0);

        // 6: reset in the middle of settling key 2
        key = 4'b0100;
        repeat (7) @(posedge clk); #1;
        chk("t6_busy_before", 32'(busy), 1);
        chk("t6_idx_before", 32'(active_idx), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_async", 32'(busy), 0);
        repeat (3) @(posedge clk); #1;
        chk("t6_level_in_rst", 32'(key_level), 0);
        chk("t6_pulse_in_rst", 32'(key_pulse), 0);
        rst_n = 1'b1;
        wait_pulse(20, e, p);
        chk("t6_lat", 32'(e), 10);
        chk("t6_pulse", 32'(p), 32'h4);
        repeat (3) @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
